// File: rtl/dac_tx_pkg.sv
// rtl/dac_tx_pkg.sv - shared types, widths and sample conversion for the DAC SPI transmitter
package dac_tx_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [DATA_W-1:0] to_offset_bin(input logic signed [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - sample stream handshake into the DAC transmitter
interface dac_spi_tx_if;
    import dac_tx_pkg::*;

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - half-period tick for sclk, realigned at every frame start
module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - serialises signed 8-bit samples into 16-bit DAC SPI frames
module dac_spi_tx
    import dac_tx_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter int         GAP     = 2,
    parameter logic [3:0] CMD     = 4'b0011
) (
    input  logic          clk,
    input  logic          rst_n,
    dac_spi_tx_if.slave   s,
    output logic          sclk,
    output logic          cs_n,
    output logic          sdo,
    output logic          busy,
    output logic          frame_done
);

    state_t                   state, state_nxt;
    logic                     hold_full;
    logic signed [DATA_W-1:0] hold_data;
    logic [FRAME_W-1:0]       frame, shreg, shreg_nxt;
    logic [4:0]               bit_cnt, bit_nxt;
    logic [7:0]               gap_cnt, gap_nxt;
    logic                     sclk_nxt, cs_nxt, fd_nxt;
    logic                     tick, start, accept, last_bit, gap_end;

    assign frame      = {CMD, to_offset_bin(hold_data), 4'b0000};
    assign last_bit   = (bit_cnt == 5'd15);
    assign gap_end    = (gap_cnt == 8'(GAP - 1));
    assign start      = (state_nxt == ST_SHIFT) && (state != ST_SHIFT);
    assign s.in_ready = !hold_full;
    assign accept     = s.in_valid && !hold_full;
    assign busy       = (state != ST_IDLE);
    assign sdo        = shreg[FRAME_W-1];

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .tick  (tick)
    );

    // The edge that launches a frame empties the holding register, so in_ready
    // is already low on that edge and a coincident sample waits one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (start) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= s.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            frame_done <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            sclk       <= sclk_nxt;
            cs_n       <= cs_nxt;
            frame_done <= fd_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hold_full) state_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && sclk && last_bit) state_nxt = ST_HOLD;
            ST_HOLD:  if (tick) state_nxt = ST_GAP;
            ST_GAP:   if (gap_end) state_nxt = hold_full ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sclk_nxt  = sclk;
        cs_nxt    = cs_n;
        fd_nxt    = 1'b0;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        if (start) begin
            cs_nxt    = 1'b0;
            sclk_nxt  = 1'b0;
            shreg_nxt = frame;
            bit_nxt   = '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (tick) begin
                        sclk_nxt = !sclk;
                        // Data only advances on the falling edge, after the DAC latched it.
                        if (sclk && !last_bit) begin
                            shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
                            bit_nxt   = bit_cnt + 5'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cs_nxt    = 1'b1;
                        shreg_nxt = '0;
                        fd_nxt    = 1'b1;
                        gap_nxt   = '0;
                    end
                end
                ST_GAP:  gap_nxt = gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - self-checking bench for dac_spi_tx against a frame-level model
module tb_dac_spi_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_spi_tx_if s0();
    dac_spi_tx_if s1();

    logic sclk0, cs0, sdo0, busy0, fd0;
    logic sclk1, cs1, sdo1, busy1, fd1;

    dac_spi_tx #(.CLK_DIV(4), .GAP(2), .CMD(4'b0011)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(s0),
        .sclk(sclk0), .cs_n(cs0), .sdo(sdo0), .busy(busy0), .frame_done(fd0)
    );

    dac_spi_tx #(.CLK_DIV(1), .GAP(1), .CMD(4'b0011)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(s1),
        .sclk(sclk1), .cs_n(cs1), .sdo(sdo1), .busy(busy1), .frame_done(fd1)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [15:0] exp_q[2][$];
    logic [15:0] got_q[2][$];
    int          low_q[2][$];
    int          nb_q[2][$];
    int          gap_q[2][$];
    int          fd_cnt[2];
    int          nbits[2];
    int          low_c[2];
    int          hi_c[2];
    logic [15:0] acc[2];
    logic        p_sclk[2];
    logic        p_cs[2];
    bit          seen[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame = command nibble 3, sample shifted up by 128 into 0..255, four zero bits.
    function automatic logic [15:0] model_frame(input logic signed [7:0] d);
        int u;
        u = int'(d) + 128;
        return 16'((3 * 4096) + (u * 16));
    endfunction

    task automatic mon_step(input int g, input logic sc, input logic cs, input logic sd, input logic fd);
        if (!rst_n) begin
            acc[g] = '0; nbits[g] = 0; low_c[g] = 0; hi_c[g] = 0;
            p_sclk[g] = 1'b0; p_cs[g] = 1'b1; seen[g] = 1'b0;
            return;
        end
        if (fd) fd_cnt[g]++;
        if (!cs) begin
            if (p_cs[g]) begin
                if (seen[g]) gap_q[g].push_back(hi_c[g]);
                low_c[g] = 0; nbits[g] = 0; acc[g] = '0;
            end
            low_c[g]++;
            if (sc && !p_sclk[g]) begin
                acc[g] = {acc[g][14:0], sd};
                nbits[g]++;
            end
        end else begin
            if (!p_cs[g]) begin
                got_q[g].push_back(acc[g]);
                low_q[g].push_back(low_c[g]);
                nb_q[g].push_back(nbits[g]);
                seen[g] = 1'b1;
                hi_c[g] = 0;
            end
            hi_c[g]++;
        end
        p_sclk[g] = sc;
        p_cs[g]   = cs;
    endtask

    always @(negedge clk) begin
        mon_step(0, sclk0, cs0, sdo0, fd0);
        mon_step(1, sclk1, cs1, sdo1, fd1);
    end

    task automatic drive(input int g, input logic v, input logic [7:0] d);
        if (g == 0) begin s0.in_valid = v; s0.in_data = d; end
        else        begin s1.in_valid = v; s1.in_data = d; end
    endtask

    function automatic logic rdy(input int g);
        return (g == 0) ? s0.in_ready : s1.in_ready;
    endfunction

    task automatic push(input int g, input logic signed [7:0] d);
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            drive(g, 1'b1, d);
            if (rdy(g)) begin
                @(posedge clk);
                #1;
                drive(g, 1'b0, 8'($urandom));
                ok = 1'b1;
            end
            n++;
        end
        if (ok) exp_q[g].push_back(model_frame(d));
        else    check("push_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_frames(input int g, input int n);
        int c = 0;
        while (got_q[g].size() < n && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (got_q[g].size() < n) check("frame_wait_timeout", 32'(got_q[g].size()), 32'(n));
    endtask

    task automatic check_frames(input int g, input int lowexp);
        check($sformatf("frame_count%0d", g), 32'(got_q[g].size()), 32'(exp_q[g].size()));
        for (int k = 0; k < got_q[g].size() && k < exp_q[g].size(); k++) begin
            check($sformatf("frame%0d_data[%0d]", g, k), 32'(got_q[g][k]), 32'(exp_q[g][k]));
            check($sformatf("frame%0d_cs_low[%0d]", g, k), 32'(low_q[g][k]), 32'(lowexp));
            check($sformatf("frame%0d_bits[%0d]", g, k), 32'(nb_q[g][k]), 32'd16);
        end
        check($sformatf("frame_done_count%0d", g), 32'(fd_cnt[g]), 32'(got_q[g].size()));
    endtask

    initial begin
        int base, gbase, c, nframes;
        logic signed [7:0] rd;

        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs0), 32'd1);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_sdo", 32'(sdo0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_frame_done", 32'(fd0), 32'd0);
        check("rst_in_ready", 32'(s0.in_ready), 32'd1);
        rst_n = 1'b1;

        // Single zero sample.
        push(0, 8'sd0);
        wait_frames(0, 1);
        check("single_frame", 32'(got_q[0][0]), 32'h3800);
        check("single_cs_low", 32'(low_q[0][0]), 32'd132);
        repeat (5) @(negedge clk);
        check("single_done_pulses", 32'(fd_cnt[0]), 32'd1);

        // Back-to-back extremes plus a third sample that must wait.
        base  = got_q[0].size();
        gbase = gap_q[0].size();
        push(0, -8'sd128);
        push(0, 8'sd127);
        check("b2b_ready_low", 32'(s0.in_ready), 32'd0);
        check("b2b_cs_low", 32'(cs0), 32'd0);
        c = 0;
        while (!s0.in_ready && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("third_held_until_frame_end", 32'(got_q[0].size()), 32'(base + 1));
        push(0, 8'sd5);
        wait_frames(0, base + 3);
        check("b2b_frame_a", 32'(got_q[0][base]), 32'h3000);
        check("b2b_frame_b", 32'(got_q[0][base + 1]), 32'h3FF0);
        check("b2b_gap_ab", 32'(gap_q[0][gbase + 1]), 32'd2);
        check("b2b_gap_bc", 32'(gap_q[0][gbase + 2]), 32'd2);

        // Ten consecutive samples 1..10.
        base  = got_q[0].size();
        gbase = gap_q[0].size();
        for (int i = 1; i <= 10; i++) push(0, 8'(i));
        wait_frames(0, base + 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("burst_data[%0d]", i), 32'(got_q[0][base + i][11:4]), 32'(8'h81 + i));
        for (int i = 1; i < 10; i++)
            check($sformatf("burst_gap[%0d]", i), 32'(gap_q[0][gbase + i]), 32'd2);

        // Random samples with random idle spacing.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            rd = 8'($urandom);
            push(0, rd);
        end
        wait_frames(0, exp_q[0].size());
        repeat (10) @(negedge clk);
        check_frames(0, 132);

        // Fastest divider: sclk toggles every clk, 33-cycle frames, 34-cycle period.
        for (int i = 0; i < 3; i++) begin
            rd = 8'($urandom);
            push(1, rd);
        end
        wait_frames(1, 3);
        repeat (5) @(negedge clk);
        check_frames(1, 33);
        check("fast_gap0", 32'(gap_q[1][0]), 32'd1);
        check("fast_gap1", 32'(gap_q[1][1]), 32'd1);

        // Reset mid-frame with a held sample.
        nframes = got_q[0].size();
        push(0, 8'sd77);
        push(0, -8'sd33);
        c = 0;
        while (!(cs0 == 1'b0 && nbits[0] == 8) && c < 2000) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("reached_bit7", 32'(nbits[0]), 32'd8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs0), 32'd1);
        check("abort_sclk", 32'(sclk0), 32'd0);
        check("abort_sdo", 32'(sdo0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_in_ready", 32'(s0.in_ready), 32'd1);
        void'(exp_q[0].pop_back());
        void'(exp_q[0].pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("no_frame_after_reset", 32'(got_q[0].size()), 32'(nframes));
        check("idle_after_reset", 32'(busy0), 32'd0);

        // First accept on the first posedge after release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd = 8'($urandom);
        drive(0, 1'b1, rd);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'($urandom));
        check("accept_first_edge", 32'(s0.in_ready), 32'd0);
        exp_q[0].push_back(model_frame(rd));
        wait_frames(0, nframes + 1);
        repeat (10) @(negedge clk);
        check_frames(0, 132);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
